// File: rtl/bps_sequencer.sv
//==============================================================================
// Module      : bps_sequencer
// Description : Upstream instruction issuer for bps_master. A single accepted
//               go plus an iteration count expands into the full TRW-S pass
//               schedule: LOAD once, then DOWN, STORE_DOWN, UP, STORE_UP per
//               iteration. Each op is a one-cycle instruction pulse; the next
//               op is issued only after the master's stall has cleared (or
//               never rose within ARM_TIMEOUT cycles) and GAP idle cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk           in   1           clock, all state on rising edge
//   rst           in   1           asynchronous reset, active low
//   go            in   1           start request, sampled only when idle
//   iterations    in   ITER_WIDTH  iteration count, latched on accepted go
//   abort         in   1           stop at the next op boundary (sticky)
//   instruction   out  3           0 IDLE,1 LOAD,2 DOWN,3 UP,4 ST_DOWN,5 ST_UP
//   master_stall  in   1           bps_master busy executing an op
//   busy          out  1           high from accepted go until back in idle
//   done          out  1           one-cycle pulse at end of run
//   aborted       out  1           run ended by abort (valid with done)
//   iter_count    out  ITER_WIDTH  completed iterations of current/last run
//==============================================================================
`default_nettype none

module bps_sequencer #(
   parameter int ITER_WIDTH  = 8,
   parameter int GAP         = 4,
   parameter int ARM_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [ITER_WIDTH-1:0] iterations,
   input  logic                  abort,
   output logic [2:0]            instruction,
   input  logic                  master_stall,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [ITER_WIDTH-1:0] iter_count
);

   localparam int TIMER_W = $clog2(ARM_TIMEOUT + 1);
   localparam int GAP_W   = $clog2(GAP + 1);

   localparam logic [TIMER_W-1:0] c_arm_limit = TIMER_W'(ARM_TIMEOUT);
   localparam logic [GAP_W-1:0]   c_gap_last  = GAP_W'(GAP - 1);

   localparam logic [2:0] c_op_idle       = 3'd0;
   localparam logic [2:0] c_op_load       = 3'd1;
   localparam logic [2:0] c_op_down       = 3'd2;
   localparam logic [2:0] c_op_up         = 3'd3;
   localparam logic [2:0] c_op_store_down = 3'd4;
   localparam logic [2:0] c_op_store_up   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_ARM    = 3'd2,
      S_WAIT   = 3'd3,
      S_GAP    = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t                r_state;
   logic [2:0]            r_op;
   logic [ITER_WIDTH-1:0] r_iters;
   logic [TIMER_W-1:0]    r_timer;
   logic [GAP_W-1:0]      r_gap;
   logic                  r_abort;
   logic                  r_last;

   state_t                w_state;
   logic [2:0]            w_op;
   logic [ITER_WIDTH-1:0] w_iters;
   logic [TIMER_W-1:0]    w_timer;
   logic [GAP_W-1:0]      w_gap;
   logic                  w_abort;
   logic                  w_last;
   logic [2:0]            w_instruction;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_aborted;
   logic [ITER_WIDTH-1:0] w_iter_count;
   logic                  w_complete;
   logic [TIMER_W-1:0]    w_timer_inc;
   logic [ITER_WIDTH-1:0] w_iter_inc;

   assign w_timer_inc = r_timer + 1'b1;
   assign w_iter_inc  = iter_count + 1'b1;

   //---------------------------------------------------------------------------
   // State and registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_op        <= c_op_idle;
         r_iters     <= '0;
         r_timer     <= '0;
         r_gap       <= '0;
         r_abort     <= 1'b0;
         r_last      <= 1'b0;
         instruction <= c_op_idle;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         iter_count  <= '0;
      end else begin
         r_state     <= w_state;
         r_op        <= w_op;
         r_iters     <= w_iters;
         r_timer     <= w_timer;
         r_gap       <= w_gap;
         r_abort     <= w_abort;
         r_last      <= w_last;
         instruction <= w_instruction;
         busy        <= w_busy;
         done        <= w_done;
         aborted     <= w_aborted;
         iter_count  <= w_iter_count;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and next-output logic. Outputs are computed for the state
   // being entered, so instruction is nonzero exactly while in ISSUE and done
   // is high the cycle after FINISH.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state       = r_state;
      w_op          = r_op;
      w_iters       = r_iters;
      w_timer       = r_timer;
      w_gap         = r_gap;
      // abort is sticky for the remainder of the run
      w_abort       = r_abort | abort;
      w_last        = r_last;
      w_instruction = c_op_idle;
      w_busy        = busy;
      w_done        = 1'b0;
      w_aborted     = aborted;
      w_iter_count  = iter_count;
      w_complete    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_abort = 1'b0;
            if (go) begin
               w_iters      = iterations;
               w_iter_count = '0;
               w_aborted    = 1'b0;
               w_busy       = 1'b1;
               w_abort      = abort;
               if (iterations == '0) begin
                  // Empty schedule counts as a normal completion
                  w_last  = 1'b1;
                  w_state = S_FINISH;
               end else begin
                  w_last        = 1'b0;
                  w_op          = c_op_load;
                  w_instruction = c_op_load;
                  w_state       = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            w_timer = '0;
            w_state = S_ARM;
         end

         S_ARM: begin
            if (master_stall) begin
               w_state = S_WAIT;
            end else begin
               // Master never acknowledged; treat the op as retired
               w_timer = w_timer_inc;
               if (w_timer_inc == c_arm_limit) begin
                  w_complete = 1'b1;
               end
            end
         end

         S_WAIT: begin
            if (!master_stall) begin
               w_complete = 1'b1;
            end
         end

         S_GAP: begin
            if (r_gap == c_gap_last) begin
               if (r_last || w_abort) begin
                  w_state = S_FINISH;
               end else begin
                  w_instruction = r_op;
                  w_state       = S_ISSUE;
               end
            end else begin
               w_gap = r_gap + 1'b1;
            end
         end

         S_FINISH: begin
            w_done    = 1'b1;
            w_busy    = 1'b0;
            // A schedule that ran to completion is never reported as aborted
            w_aborted = r_abort & ~r_last;
            w_abort   = 1'b0;
            w_state   = S_IDLE;
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase

      // Retire the op in flight and choose the next one
      if (w_complete) begin
         w_state = S_GAP;
         w_gap   = '0;
         case (r_op)
            c_op_load:       w_op = c_op_down;
            c_op_down:       w_op = c_op_store_down;
            c_op_store_down: w_op = c_op_up;
            c_op_up:         w_op = c_op_store_up;
            c_op_store_up: begin
               w_iter_count = w_iter_inc;
               w_op         = c_op_down;
               if (w_iter_inc == r_iters) begin
                  w_last = 1'b1;
               end
            end
            default:         w_op = c_op_idle;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bps_sequencer.sv
//==============================================================================
// Module      : tb_bps_sequencer
// Description : Self-checking bench for bps_sequencer with a bps_master stub
//               (stall rises one cycle after a nonzero instruction and holds
//               for a configurable number of cycles).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bps_sequencer;

   localparam int ITER_WIDTH  = 8;
   localparam int GAP         = 4;
   localparam int ARM_TIMEOUT = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  go = 1'b0;
   logic                  abort = 1'b0;
   logic [ITER_WIDTH-1:0] iterations = '0;
   logic [2:0]            instruction;
   logic                  master_stall;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic [ITER_WIDTH-1:0] iter_count;

   always #5 clk = ~clk;

   bps_sequencer #(
      .ITER_WIDTH  (ITER_WIDTH),
      .GAP         (GAP),
      .ARM_TIMEOUT (ARM_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .go           (go),
      .iterations   (iterations),
      .abort        (abort),
      .instruction  (instruction),
      .master_stall (master_stall),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .iter_count   (iter_count)
   );

   // bps_master stub
   int stall_n = 0;
   int stall_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst)                  stall_cnt <= 0;
      else if (instruction != 0) stall_cnt <= stall_n;
      else if (stall_cnt > 0)    stall_cnt <= stall_cnt - 1;
   end
   assign master_stall = (stall_cnt != 0);

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard of expected instruction pulses
   logic [2:0] exp_q[$];
   int  pulses, dones, store_ups, zero_run, exp_spacing;
   bit  first_pulse;
   logic [2:0] prev_instr;
   logic [2:0] e;

   always @(negedge clk) begin
      if (rst) begin
         if (instruction != 3'd0) begin
            check("pulse_width", int'(prev_instr), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", int'(instruction), 0);
            end else begin
               e = exp_q.pop_front();
               check("instr_order", int'(instruction), int'(e));
            end
            check("iter_at_pulse", int'(iter_count), store_ups);
            if (!first_pulse) check("op_spacing", zero_run, exp_spacing);
            if (instruction == 3'd5) store_ups++;
            first_pulse = 1'b0;
            zero_run    = 0;
            pulses++;
         end else begin
            zero_run++;
         end
         if (done) dones++;
         prev_instr = instruction;
      end else begin
         prev_instr = 3'd0;
         zero_run   = 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [2:0] model_op(input int k);
      logic [2:0] r;
      if (k == 0) r = 3'd1;
      else begin
         case ((k - 1) % 4)
            0:       r = 3'd2;
            1:       r = 3'd4;
            2:       r = 3'd3;
            default: r = 3'd5;
         endcase
      end
      return r;
   endfunction

   typedef struct {
      int iters;
      int stall;        // stub stall length, 0 = never stalls
      int abort_after;  // -1 none, 0 with go, k = during WAIT after pulse k
      int exp_pulses;
      int exp_iter;
      int exp_aborted;
   } vec_t;

   task automatic prepare(input vec_t v);
      exp_q.delete();
      for (int k = 0; k < v.exp_pulses; k++) exp_q.push_back(model_op(k));
      stall_n     = v.stall;
      exp_spacing = (v.stall > 0) ? v.stall + GAP + 1 : ARM_TIMEOUT + GAP;
      first_pulse = 1'b1;
      store_ups   = 0;
      pulses      = 0;
      dones       = 0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      prepare(v);
      tick();
      iterations = ITER_WIDTH'(v.iters);
      go    = 1'b1;
      abort = (v.abort_after == 0);
      tick();
      go    = 1'b0;
      abort = 1'b0;
      check("busy_after_go", int'(busy), 1);
      if (v.abort_after > 0) begin
         n = 0;
         while (pulses < v.abort_after && n < 3000) begin tick(); n++; end
         check("abort_point_reached", pulses, v.abort_after);
         repeat (3) tick();
         abort = 1'b1;
         tick();
         abort = 1'b0;
      end
      n = 0;
      while (!done && n < 3000) begin tick(); n++; end
      check("done_seen", int'(done), 1);
      check("iter_count_at_done", int'(iter_count), v.exp_iter);
      check("aborted_at_done", int'(aborted), v.exp_aborted);
      check("busy_at_done", int'(busy), 0);
      repeat (20) tick();
      check("pulse_count", pulses, v.exp_pulses);
      check("queue_empty", exp_q.size(), 0);
      check("done_count", dones, 1);
      check("iter_count_hold", int'(iter_count), v.exp_iter);
      check("aborted_hold", int'(aborted), v.exp_aborted);
   endtask

   vec_t vecs[5];

   initial begin
      int n;
      vecs[0] = '{1, 10, -1,  5, 1, 0};
      vecs[1] = '{3,  5, -1, 13, 3, 0};
      vecs[2] = '{2,  0, -1,  9, 2, 0};
      vecs[3] = '{3,  5,  6,  6, 1, 1};   // abort during WAIT of 2nd DOWN
      vecs[4] = '{2,  5,  0,  1, 0, 1};   // go and abort together

      // Reset state
      repeat (3) tick();
      check("rst_instruction", int'(instruction), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_aborted", int'(aborted), 0);
      check("rst_iter_count", int'(iter_count), 0);
      rst = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Zero iterations: no ops, done two cycles after go, busy for one cycle
      prepare('{0, 5, -1, 0, 0, 0});
      iterations = '0;
      go = 1'b1;
      tick();
      go = 1'b0;
      check("zero_busy_c1", int'(busy), 1);
      check("zero_done_c1", int'(done), 0);
      tick();
      check("zero_busy_c2", int'(busy), 0);
      check("zero_done_c2", int'(done), 1);
      check("zero_iter_count", int'(iter_count), 0);
      check("zero_aborted_cleared", int'(aborted), 0);
      tick();
      check("zero_done_c3", int'(done), 0);
      repeat (5) tick();
      check("zero_pulses", pulses, 0);

      // Reset during WAIT with go pulsed while busy
      prepare('{3, 5, -1, 13, 3, 0});
      iterations = 8'd3;
      go = 1'b1;
      tick();
      go = 1'b0;
      n = 0;
      while (pulses < 6 && n < 3000) begin tick(); n++; end
      check("mid_point_reached", pulses, 6);
      tick();
      iterations = 8'd1;
      go = 1'b1;
      tick();
      go = 1'b0;
      check("go_ignored_busy", int'(busy), 1);
      check("go_ignored_iter", int'(iter_count), 1);
      check("go_ignored_stall", int'(master_stall), 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_instruction", int'(instruction), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      check("async_rst_aborted", int'(aborted), 0);
      check("async_rst_iter_count", int'(iter_count), 0);
      exp_q.delete();
      dones = 0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (10) tick();
      check("no_done_after_rst", dones, 0);
      check("idle_after_rst", int'(busy), 0);

      // Clean restart after reset
      run_vec('{1, 10, -1, 5, 1, 0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
